// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC sequencer with redirect, stall and memory-wait handling.
// Optional PC_ALIGN_CHECK_EN traps misaligned redirect targets to TRAP_VEC.
module pc_fetch_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] TRAP_VEC = 9'h1F0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            PC_sel,
    input  logic [31:0]     branch_PC,
    input  logic            imem_ready,
    output logic [PC_W-1:0] PC,
    output logic            fetch_valid,
    output logic            flush_IF_ID,
    output logic            flush_ID_EX,
    output logic [15:0]     redirect_cnt,
    output logic            misalign_trap
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, BUBBLE} state_t;

    state_t          r_state, w_nstate;
    logic [PC_W-1:0] r_pc, w_npc, r_pend_pc, w_npend_pc, w_tgt, w_inc;
    logic            r_pend_vld, w_npend_vld, w_accept, w_unused;
    logic [15:0]     r_cnt;

    assign w_unused = ^{branch_PC, TRAP_VEC};
    assign w_inc    = r_pc + PC_W'(4);

`ifdef PC_ALIGN_CHECK_EN
    logic r_trap, w_mis;
    assign w_mis         = |branch_PC[1:0];
    assign w_tgt         = w_mis ? TRAP_VEC : branch_PC[PC_W-1:0];
    assign misalign_trap = r_trap;
    always_ff @(posedge clk) begin
        if (!reset_n) r_trap <= 1'b0;
        else          r_trap <= r_trap | (w_accept & w_mis);
    end
`else
    assign w_tgt         = {branch_PC[PC_W-1:2], 2'b00};
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        w_nstate    = r_state;
        w_npc       = r_pc;
        w_npend_vld = r_pend_vld;
        w_npend_pc  = r_pend_pc;
        w_accept    = 1'b0;
        case (r_state)
            BOOT: begin
                w_nstate = RUN;
                w_npc    = '0;
            end
            RUN: begin
                if (PC_sel) begin
                    w_accept = 1'b1;
                    w_npc    = w_tgt;
                    w_nstate = BUBBLE;
                end else if (!stall && !imem_ready) begin
                    w_nstate = WAIT_MEM;
                end else if (!stall) begin
                    w_npc = w_inc;
                end
            end
            BUBBLE: begin
                w_accept = PC_sel;
                w_npc    = PC_sel ? w_tgt : r_pc;
                w_nstate = PC_sel ? BUBBLE : RUN;
            end
            WAIT_MEM: begin
                w_accept = PC_sel;
                if (PC_sel) begin
                    w_npend_vld = 1'b1;
                    w_npend_pc  = w_tgt;
                end
                // a same-cycle redirect is newer than anything pending
                if (imem_ready) begin
                    w_npend_vld = 1'b0;
                    w_nstate    = (PC_sel || r_pend_vld) ? BUBBLE : RUN;
                    w_npc       = PC_sel ? w_tgt : (r_pend_vld ? r_pend_pc : w_inc);
                end
            end
            default: w_nstate = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_pc       <= '0;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_nstate;
            r_pc       <= w_npc;
            r_pend_vld <= w_npend_vld;
            r_pend_pc  <= w_npend_pc;
            if (w_accept && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign PC           = r_pc;
    assign fetch_valid  = (r_state == RUN) || (r_state == WAIT_MEM);
    assign flush_IF_ID  = w_accept & reset_n;
    assign flush_ID_EX  = w_accept & reset_n;
    assign redirect_cnt = r_cnt;
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning PC register width in bits.
REQ-002 SHALL have parameter TRAP_VEC, default 9'h1F0, meaning PC loaded on misaligned redirect (only used when PC_ALIGN_CHECK_EN is defined).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port stall, input, 1, hazard-unit request to hold PC.
REQ-006 SHALL have port PC_sel, input, 1, branch-unit request to redirect.
REQ-007 SHALL have port branch_PC, input, 32, redirect target.
REQ-008 SHALL have port imem_ready, input, 1, instruction memory accepts the current PC.
REQ-009 SHALL have port PC, output, PC_W, current fetch address.
REQ-010 SHALL have port fetch_valid, output, 1, PC is a valid fetch this cycle.
REQ-011 SHALL have port flush_IF_ID, output, 1, squash IF/ID register.
REQ-012 SHALL have port flush_ID_EX, output, 1, squash ID/EX register.
REQ-013 SHALL have port redirect_cnt, output, 16, count of taken redirects.
REQ-014 SHALL have port misalign_trap, output, 1, sticky misaligned-target flag.

Function
REQ-015 SHALL implement states BOOT, RUN, WAIT_MEM, BUBBLE.
REQ-016 BOOT: fetch_valid=0, PC=0; next state RUN unconditionally.
REQ-017 RUN: fetch_valid=1; if PC_sel, PC <= branch_PC[PC_W-1:0] and go BUBBLE; else if stall, PC holds; else if !imem_ready, PC holds and go WAIT_MEM; else PC <= PC+4.
REQ-018 Priority SHALL be PC_sel > stall > imem_ready.
REQ-019 flush_IF_ID and flush_ID_EX SHALL be combinational, both high in exactly the cycle a redirect is accepted, low otherwise.
REQ-020 BUBBLE: fetch_valid=0 for one cycle, PC holds the target; next state RUN; a PC_sel in BUBBLE SHALL be accepted as a new redirect (stays BUBBLE, flushes asserted).
REQ-021 WAIT_MEM: fetch_valid=1, PC holds; PC_sel SHALL be captured into a pending register (latest wins) with flushes asserted that cycle; on imem_ready=1 a pending target loads into PC and state goes BUBBLE, else PC <= PC+4 and state goes RUN.
REQ-022 PC+4 SHALL wrap modulo 2^PC_W (e.g. PC_W=9: 9'h1FC -> 9'h000).
REQ-023 branch_PC bits above PC_W SHALL be ignored.
REQ-024 redirect_cnt SHALL increment once per accepted redirect and saturate at 16'hFFFF.
REQ-025 Latency: redirect target SHALL appear on PC one cycle after PC_sel is accepted (RUN/BUBBLE).

Reset
REQ-026 While reset_n=0 at a clock edge: state BOOT, PC=0, fetch_valid=0, redirect_cnt=0, pending cleared, misalign_trap=0.
REQ-027 Reset SHALL override all inputs including a simultaneous PC_sel; flush outputs SHALL be 0 while reset_n=0.
REQ-028 Reset mid-WAIT_MEM SHALL discard any pending redirect.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN: when defined, an accepted redirect with branch_PC[1:0]!=0 SHALL load TRAP_VEC instead, set misalign_trap (sticky until reset), and still flush and count.
REQ-030 Without PC_ALIGN_CHECK_EN: branch_PC[1:0] SHALL be forced to 00 on load and misalign_trap tied 0.

Verification
REQ-031 Release reset, imem_ready=1, no stall -> PC 0,0(BOOT),4,8,C; fetch_valid 0 then 1.
REQ-032 PC=0x20, PC_sel=1, branch_PC=0x40, stall=1 same cycle -> both flushes high that cycle, PC=0x40 next, fetch_valid=0 one cycle, redirect_cnt=1.
REQ-033 PC=0x10, imem_ready=0 3 cycles with PC_sel pulse branch_PC=0x80 in cycle 2 -> PC holds 0x10, flushes in cycle 2, PC=0x80 after imem_ready returns.
REQ-034 PC_W=9, PC=0x1FC, free-run -> PC=0x000 next.
REQ-035 With PC_ALIGN_CHECK_EN, branch_PC=0x42 -> PC=TRAP_VEC, misalign_trap=1 held; without macro -> PC=0x40, misalign_trap=0.
REQ-036 Drive 65540 redirects -> redirect_cnt=16'hFFFF; reset_n=0 one edge -> counter 0, PC 0.
